fp_norm_pack: RTL and testbench

Iterative normalize-and-pack stage for the FFT complex-multiplier floating-point datapath. It consumes the unnormalized sign/magnitude sum produced by the mantissa add/subtract stage: a 24-bit magnitude with explicit hidden bit, a carry-out, an 8-bit biased exponent and a sign. It emits an IEEE-754 single-precision word. A valid/ready handshake sits on both sides, and a one-bit-per-cycle shift FSM renormalizes the magnitude.

---
 rtl/fp_norm_pkg.sv | 9 +
 rtl/fp_norm_pack.sv | 98 +++++++++
 tb/tb_fp_norm_pack.sv | 114 +++++++++++
 3 files changed

// File: rtl/fp_norm_pkg.sv
// fp_norm_pkg: shared states, widths and exponent constants for fp_norm_pack
package fp_norm_pkg;
  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
  localparam int MANT_W_DEF = 24;
  localparam int EXP_W_DEF = 8;
  localparam logic [EXP_W_DEF-1:0] EXP_MAX_FINITE = 8'hFE;
  localparam logic [EXP_W_DEF-1:0] EXP_INF = 8'hFF;
  localparam int BIAS = 127;
endpackage

// File: rtl/fp_norm_pack.sv
// fp_norm_pack: iterative one-bit-per-cycle normalize and pack to IEEE-754 single
// FP_NORM_FLAGS_EN adds registered ovf/unf/zero outputs
module fp_norm_pack
  import fp_norm_pkg::*;
#(
  parameter int MANT_W = MANT_W_DEF,
  parameter int EXP_W = EXP_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic [MANT_W-1:0] in_mant,
  input  logic in_carry,
  input  logic [EXP_W-1:0] in_exp,
  input  logic in_sign,
  output logic out_valid,
  input  logic out_ready,
  output logic [EXP_W+MANT_W-1:0] out_result
`ifdef FP_NORM_FLAGS_EN
  ,
  output logic ovf,
  output logic unf,
  output logic zero
`endif
);
  state_t state;
  logic [MANT_W-1:0] mant;
  logic carry;
  logic [EXP_W-1:0] exp;
  logic sign;
  logic hit_ovf, hit_zero, hit_norm, hit_den, finish, flag_unf;
  logic [EXP_W+MANT_W-1:0] res;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    hit_ovf = carry && exp >= EXP_MAX_FINITE;
    hit_zero = !carry && mant == '0;
    hit_norm = !carry && mant[MANT_W-1];
    hit_den = !carry && mant != '0 && !mant[MANT_W-1] && exp <= EXP_W'(1);
    finish = hit_ovf | hit_zero | hit_norm | hit_den;
    flag_unf = hit_den | (hit_norm && exp == '0);
    res = hit_ovf ? {sign, EXP_INF, {(MANT_W-1){1'b0}}} :
          hit_zero ? '0 :
          hit_norm ? {sign, exp, mant[MANT_W-2:0]} :
                     {sign, {EXP_W{1'b0}}, mant[MANT_W-2:0]};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      mant <= '0;
      carry <= 1'b0;
      exp <= '0;
      sign <= 1'b0;
      out_result <= '0;
`ifdef FP_NORM_FLAGS_EN
      ovf <= 1'b0;
      unf <= 1'b0;
      zero <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          mant <= in_mant;
          carry <= in_carry;
          exp <= in_exp;
          sign <= in_sign;
          state <= NORM;
        end
        NORM: if (finish) begin
          out_result <= res;
`ifdef FP_NORM_FLAGS_EN
          ovf <= hit_ovf;
          unf <= flag_unf;
          zero <= hit_zero;
`endif
          state <= DONE;
        end else if (carry) begin
          mant <= {1'b1, mant[MANT_W-1:1]};
          exp <= exp + 1'b1;
          carry <= 1'b0;
        end else begin
          mant <= mant << 1;
          exp <= exp - 1'b1;
        end
        DONE: if (out_ready) begin
`ifdef FP_NORM_FLAGS_EN
          ovf <= 1'b0;
          unf <= 1'b0;
          zero <= 1'b0;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_norm_pack.sv
// tb_fp_norm_pack: directed vectors with hand-computed results, latency and handshake checks
module tb_fp_norm_pack;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [23:0] in_mant = '0;
  logic in_carry = 1'b0;
  logic [7:0] in_exp = '0;
  logic in_sign = 1'b0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [31:0] out_result;
  logic [2:0] flags;
  int n_cmp = 0;
  int n_bad = 0;
`ifdef FP_NORM_FLAGS_EN
  logic ovf, unf, zero;
  assign flags = {ovf, unf, zero};
`else
  assign flags = 3'b000;
`endif

  fp_norm_pack dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_mant(in_mant), .in_carry(in_carry), .in_exp(in_exp), .in_sign(in_sign),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result)
`ifdef FP_NORM_FLAGS_EN
    , .ovf(ovf), .unf(unf), .zero(zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic chk_flags(input string tag, input logic [2:0] want);
`ifdef FP_NORM_FLAGS_EN
    chk(tag, 64'(flags), 64'(want));
`endif
  endtask

  task automatic launch(input logic [23:0] m, input logic c, input logic [7:0] e, input logic s);
    @(negedge clk);
    in_mant = m; in_carry = c; in_exp = e; in_sign = s; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic op(input string tag, input logic [23:0] m, input logic c, input logic [7:0] e,
                    input logic s, input logic [31:0] want, input int want_lat,
                    input logic [2:0] want_flags, input int hold);
    int lat;
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    launch(m, c, e, s);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1 lat++;
    end
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_lat"}, 64'(lat), 64'(want_lat));
    chk({tag, "_res"}, 64'(out_result), 64'(want));
    chk_flags({tag, "_flags"}, want_flags);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_res"}, 64'(out_result), 64'(want));
      chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({tag, "_released"}, 64'(out_valid), 64'd0);
    chk({tag, "_in_ready_back"}, 64'(in_ready), 64'd1);
    chk_flags({tag, "_flags_clr"}, 3'b000);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_result", 64'(out_result), 64'd0);
    chk_flags("rst_flags", 3'b000);
    rst = 1'b0;
    op("one", 24'h800000, 1'b0, 8'h7F, 1'b0, 32'h3F800000, 1, 3'b000, 0);
    op("carry", 24'h000000, 1'b1, 8'h7F, 1'b0, 32'h40000000, 2, 3'b000, 5);
    op("shift23", 24'h000001, 1'b0, 8'h7F, 1'b1, 32'hB4000000, 24, 3'b000, 0);
    op("ovf", 24'h000000, 1'b1, 8'hFE, 1'b0, 32'h7F800000, 1, 3'b100, 0);
    op("zero", 24'h000000, 1'b0, 8'h55, 1'b1, 32'h00000000, 1, 3'b001, 0);
    op("denorm", 24'h400000, 1'b0, 8'h01, 1'b0, 32'h00400000, 1, 3'b010, 0);
    op("exp0", 24'h800001, 1'b0, 8'h00, 1'b1, 32'h80000001, 1, 3'b010, 0);
    launch(24'h000001, 1'b0, 8'h7F, 1'b1);
    repeat (5) @(posedge clk);
    #1 chk("mid_norm_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_result", 64'(out_result), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    op("after_rst", 24'h800000, 1'b0, 8'h7F, 1'b0, 32'h3F800000, 1, 3'b000, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
